mem_access_stage: RTL and testbench

//  Memory-access pipeline stage of the 8-bit RISC CPU, between execute and writeback.

---
 rtl/mem_access_stage.sv | 122 ++++++++++++
 tb/tb_mem_access_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores to a registered-read data memory and
// hands one result slot at a time to writeback over a valid/ready handshake.
module mem_access_stage #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int REG_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [REG_W-1:0]  req_rd,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_rd,
   output logic              wb_we,
   output logic [7:0]        stat_loads,
   output logic [7:0]        stat_stores,
   output logic              err_sticky
);

   localparam logic [1:0] OP_PASS    = 2'b00;
   localparam logic [1:0] OP_LOAD    = 2'b01;
   localparam logic [1:0] OP_STORE   = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   typedef enum logic {IDLE, LOAD_WAIT} state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              accept;
   logic [REG_W-1:0]  load_rd_reg;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: a load always waits exactly one cycle for its data
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (accept && req_op == OP_LOAD) state_next = LOAD_WAIT;
         LOAD_WAIT: state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   // Output logic: handshake and memory port are combinational from the request
   always_comb begin
      req_ready      = rst_n && (state_reg == IDLE) && (!wb_valid || wb_ready);
      accept         = req_valid && req_ready;
      mem_address    = req_addr;
      mem_write_data = req_wdata;
      mem_read       = accept && (req_op == OP_LOAD);
      mem_write      = accept && (req_op == OP_STORE);
   end

   // Result slot, statistics and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid    <= 1'b0;
         wb_data     <= '0;
         wb_rd       <= '0;
         wb_we       <= 1'b0;
         load_rd_reg <= '0;
         stat_loads  <= '0;
         stat_stores <= '0;
         err_sticky  <= 1'b0;
      end else if (accept) begin
         case (req_op)
            OP_PASS: begin
               wb_valid <= 1'b1;
               wb_data  <= DATA_W'(req_addr);
               wb_rd    <= req_rd;
               wb_we    <= 1'b1;
            end
            OP_LOAD: begin
               // Slot is empty or draining this edge; it refills from LOAD_WAIT
               wb_valid    <= 1'b0;
               load_rd_reg <= req_rd;
               stat_loads  <= stat_loads + 8'd1;
            end
            OP_STORE: begin
               wb_valid    <= 1'b1;
               wb_data     <= '0;
               wb_rd       <= req_rd;
               wb_we       <= 1'b0;
               stat_stores <= stat_stores + 8'd1;
            end
            default: begin
               wb_valid   <= 1'b1;
               wb_data    <= '0;
               wb_rd      <= req_rd;
               wb_we      <= 1'b0;
               err_sticky <= 1'b1;
            end
         endcase
      end else if (state_reg == LOAD_WAIT) begin
         wb_valid <= 1'b1;
         wb_data  <= mem_read_data;
         wb_rd    <= load_rd_reg;
         wb_we    <= 1'b1;
      end else if (wb_valid && wb_ready) begin
         wb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a registered-read memory model.
module tb_mem_access_stage;

   localparam logic [1:0] OP_PASS    = 2'b00;
   localparam logic [1:0] OP_LOAD    = 2'b01;
   localparam logic [1:0] OP_STORE   = 2'b10;
   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic [2:0] req_rd;
   logic [7:0] mem_address;
   logic [7:0] mem_write_data;
   logic       mem_read;
   logic       mem_write;
   logic [7:0] mem_read_data;
   logic       wb_valid;
   logic       wb_ready;
   logic [7:0] wb_data;
   logic [2:0] wb_rd;
   logic       wb_we;
   logic [7:0] stat_loads;
   logic [7:0] stat_stores;
   logic       err_sticky;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mem_model [256];
   bit         mem_init_done = 1'b0;
   int         wr_count = 0;

   mem_access_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_rd         (req_rd),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_data        (wb_data),
      .wb_rd          (wb_rd),
      .wb_we          (wb_we),
      .stat_loads     (stat_loads),
      .stat_stores    (stat_stores),
      .err_sticky     (err_sticky)
   );

   always #5 clk = ~clk;

   // Data memory: unwritten words hold addr ^ 0x5C, read data registered
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5C;
         mem_init_done = 1'b1;
      end
      if (mem_write) begin
         mem_model[mem_address] = mem_write_data;
         wr_count = wr_count + 1;
      end
      if (mem_read) mem_read_data <= mem_model[mem_address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] d, input logic [2:0] rd);
      req_valid = v;
      req_op    = op;
      req_addr  = a;
      req_wdata = d;
      req_rd    = rd;
   endtask

   logic [7:0] load_tbl [4];

   initial begin
      load_tbl[0] = 8'h7C; load_tbl[1] = 8'h7D; load_tbl[2] = 8'h7E; load_tbl[3] = 8'h7F;
      mem_read_data = 8'h00;
      wb_ready = 1'b1;
      rst_n = 1'b0;

      // 1: reset blocks the handshake and clears state
      drive(1'b1, OP_LOAD, 8'h10, 8'h00, 3'd0);
      tick; tick;
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_read", mem_read, 0);
      drive(1'b1, OP_STORE, 8'h10, 8'h00, 3'd0);
      #1;
      check("rst_mem_write", mem_write, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_stats", {stat_loads, stat_stores}, 0);
      check("rst_err", err_sticky, 0);
      req_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", req_ready, 1);
      tick;

      // 2: store then load back
      drive(1'b1, OP_STORE, 8'h10, 8'h5A, 3'd0);
      #1;
      check("st_mem_write", mem_write, 1);
      check("st_mem_addr", mem_address, 8'h10);
      tick;
      check("st_wb_valid", wb_valid, 1);
      check("st_wb_we", wb_we, 0);
      check("st_wb_data", wb_data, 0);
      check("st_count", stat_stores, 1);
      drive(1'b1, OP_LOAD, 8'h10, 8'h00, 3'd3);
      #1;
      check("ld_accept", req_ready, 1);
      check("ld_mem_read", mem_read, 1);
      check("ld_no_write", mem_write, 0);
      tick;
      req_valid = 1'b0;
      check("ld_wait_valid", wb_valid, 0);
      check("ld_wait_ready", req_ready, 0);
      tick;
      check("ld_wb_valid", wb_valid, 1);
      check("ld_wb_data", wb_data, 8'h5A);
      check("ld_wb_rd", wb_rd, 3);
      check("ld_wb_we", wb_we, 1);
      check("wr_pulses", wr_count, 1);

      // 3: backpressure hold, then drain+accept on one edge
      tick;
      check("drain_valid", wb_valid, 0);
      wb_ready = 1'b0;
      drive(1'b1, OP_PASS, 8'h77, 8'h00, 3'd5);
      #1;
      check("pass_ready", req_ready, 1);
      tick;
      check("pass_valid", wb_valid, 1);
      check("pass_data", wb_data, 8'h77);
      check("pass_rd", wb_rd, 5);
      check("pass_we", wb_we, 1);
      drive(1'b1, OP_PASS, 8'h22, 8'h00, 3'd1);
      #1;
      check("bp_ready", req_ready, 0);
      tick;
      check("bp_hold_valid", wb_valid, 1);
      check("bp_hold_data", wb_data, 8'h77);
      check("bp_hold_rd", wb_rd, 5);
      wb_ready = 1'b1;
      #1;
      check("drain_ready", req_ready, 1);
      tick;
      check("refill_valid", wb_valid, 1);
      check("refill_data", wb_data, 8'h22);
      check("refill_rd", wb_rd, 1);
      req_valid = 1'b0;
      tick;
      check("refill_drained", wb_valid, 0);

      // 4: back-to-back loads, one accept every second cycle
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, OP_LOAD, 8'h20 + 8'(k), 8'h00, 3'(k));
         #1;
         check("b2b_ready_idle", req_ready, 1);
         tick;
         check("b2b_wait_valid", wb_valid, 0);
         check("b2b_wait_ready", req_ready, 0);
         check("b2b_wait_read", mem_read, 0);
         tick;
         check("b2b_valid", wb_valid, 1);
         check("b2b_data", wb_data, load_tbl[k]);
         check("b2b_rd", wb_rd, 32'(k));
      end
      req_valid = 1'b0;
      check("b2b_loads", stat_loads, 4);

      // 5: reset during LOAD_WAIT abandons the load
      drive(1'b1, OP_LOAD, 8'h30, 8'h00, 3'd2);
      tick;
      req_valid = 1'b0;
      check("abort_loads_pre", stat_loads, 5);
      check("abort_in_wait", req_ready, 0);
      rst_n = 1'b0;
      #1;
      check("abort_wb_valid", wb_valid, 0);
      check("abort_loads", stat_loads, 0);
      #2;
      rst_n = 1'b1;
      tick;
      check("abort_no_wb", wb_valid, 0);
      check("abort_idle", req_ready, 1);
      tick;
      check("abort_no_wb2", wb_valid, 0);

      // 6: illegal op, then 256 stores to wrap the counter
      drive(1'b1, OP_ILLEGAL, 8'h40, 8'h11, 3'd4);
      #1;
      check("ill_no_read", mem_read, 0);
      check("ill_no_write", mem_write, 0);
      check("ill_ready", req_ready, 1);
      tick;
      req_valid = 1'b0;
      check("ill_wb_valid", wb_valid, 1);
      check("ill_wb_we", wb_we, 0);
      check("ill_wb_data", wb_data, 0);
      check("ill_err", err_sticky, 1);
      check("ill_no_store", stat_stores, 0);
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, OP_STORE, 8'(i), 8'(i) ^ 8'hFF, 3'd0);
         #1;
         if (i == 0) check("wrap_first_write", mem_write, 1);
         tick;
         if (i == 254) check("wrap_255", stat_stores, 255);
      end
      req_valid = 1'b0;
      check("wrap_zero", stat_stores, 0);
      check("wrap_err_held", err_sticky, 1);
      check("wrap_wr_pulses", wr_count, 257);
      check("wrap_wb_we", wb_we, 0);
      check("wrap_loads_kept", stat_loads, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
